// File: rtl/mac_pkg.sv
// Shared FloPoCo FP64 encodings, accumulator FSM states and behavioural models of the
// multiplier/adder cores (round-to-nearest-even, no subnormals).
package mac_pkg;

    localparam int unsigned FPC_W       = 66;
    localparam int unsigned EXP_W       = 11;
    localparam int unsigned FRAC_W      = 52;
    localparam int unsigned MUL_LAT_DEF = 6;
    localparam int unsigned ADD_LAT_DEF = 8;

    localparam logic [1:0] ExnZero   = 2'b00;
    localparam logic [1:0] ExnNormal = 2'b01;
    localparam logic [1:0] ExnInf    = 2'b10;
    localparam logic [1:0] ExnNan    = 2'b11;

    typedef struct packed {
        logic [1:0]        exn;
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fpc_t;

    typedef enum logic [2:0] {StIdle, StAcc, StAddWait, StEmit, StFlush} acc_state_e;

    function automatic fpc_t fpc_special(input logic [1:0] exn, input logic sign);
        fpc_t r;
        r.exn  = exn;
        r.sign = sign;
        r.exp  = '0;
        r.frac = '0;
        return r;
    endfunction

    // Denormal inputs (exp == 0) become signed zero.
    function automatic fpc_t ieee_to_fpc(input logic [63:0] v);
        fpc_t r;
        r.sign = v[63];
        r.exp  = v[62:52];
        r.frac = v[51:0];
        if (v[62:52] == '0) begin
            r = fpc_special(ExnZero, v[63]);
        end else if (v[62:52] == '1) begin
            r = fpc_special((v[51:0] == '0) ? ExnInf : ExnNan, (v[51:0] == '0) ? v[63] : 1'b0);
        end else begin
            r.exn = ExnNormal;
        end
        return r;
    endfunction

    // m carries the hidden bit; e is the biased exponent before rounding.
    function automatic fpc_t round_pack(input logic sign, input logic signed [13:0] e,
                                        input logic [52:0] m, input logic g, input logic st);
        logic [53:0]        mr;
        logic signed [13:0] er;
        fpc_t               r;
        mr = {1'b0, m} + {53'd0, g & (st | m[0])};
        er = e;
        if (mr[53]) begin
            mr = mr >> 1;
            er = er + 14'sd1;
        end
        r.exn  = ExnNormal;
        r.sign = sign;
        r.exp  = er[10:0];
        r.frac = mr[51:0];
        if (er >= 14'sd2047) begin
            r = fpc_special(ExnInf, sign);
        end else if (er <= 14'sd0) begin
            r = fpc_special(ExnZero, sign);
        end
        return r;
    endfunction

    function automatic fpc_t fpc_mul(input fpc_t a, input fpc_t b);
        logic               s;
        logic [105:0]       p;
        logic signed [13:0] e;
        s = a.sign ^ b.sign;
        if (a.exn == ExnNan || b.exn == ExnNan ||
            (a.exn == ExnInf && b.exn == ExnZero) || (a.exn == ExnZero && b.exn == ExnInf)) begin
            return fpc_special(ExnNan, 1'b0);
        end
        if (a.exn == ExnInf || b.exn == ExnInf) return fpc_special(ExnInf, s);
        if (a.exn == ExnZero || b.exn == ExnZero) return fpc_special(ExnZero, s);
        p = {53'd0, 1'b1, a.frac} * {53'd0, 1'b1, b.frac};
        e = $signed({3'b000, a.exp}) + $signed({3'b000, b.exp}) - 14'sd1023;
        if (p[105]) return round_pack(s, e + 14'sd1, p[105:53], p[52], |p[51:0]);
        return round_pack(s, e, p[104:52], p[51], |p[50:0]);
    endfunction

    function automatic fpc_t fpc_add(input fpc_t a, input fpc_t b);
        fpc_t               x;
        fpc_t               y;
        logic [56:0]        mx;
        logic [56:0]        my;
        logic [56:0]        sh;
        logic [56:0]        sum;
        logic signed [13:0] e;
        int                 d;
        if (a.exn == ExnNan || b.exn == ExnNan ||
            (a.exn == ExnInf && b.exn == ExnInf && a.sign != b.sign)) begin
            return fpc_special(ExnNan, 1'b0);
        end
        if (a.exn == ExnInf) return a;
        if (b.exn == ExnInf) return b;
        if (a.exn == ExnZero && b.exn == ExnZero) return fpc_special(ExnZero, a.sign & b.sign);
        if (a.exn == ExnZero) return b;
        if (b.exn == ExnZero) return a;
        x = a;
        y = b;
        if ({b.exp, b.frac} > {a.exp, a.frac}) begin
            x = b;
            y = a;
        end
        // Layout: carry, hidden, 52 fraction bits, guard/round/sticky.
        mx = {1'b0, 1'b1, x.frac, 3'b000};
        my = {1'b0, 1'b1, y.frac, 3'b000};
        d  = int'(x.exp) - int'(y.exp);
        if (d > 56) d = 56;
        sh    = my >> d;
        sh[0] = sh[0] | ((sh << d) != my);
        sum   = (x.sign != y.sign) ? mx - sh : mx + sh;
        e     = $signed({3'b000, x.exp});
        if (sum == '0) return fpc_special(ExnZero, 1'b0);
        if (sum[56]) begin
            sum = {1'b0, sum[56:2], sum[1] | sum[0]};
            e   = e + 14'sd1;
        end else begin
            for (int i = 0; i < 56; i++) begin
                if (!sum[55]) begin
                    sum = sum << 1;
                    e   = e - 14'sd1;
                end
            end
        end
        return round_pack(x.sign, e, sum[55:3], sum[2], sum[1] | sum[0]);
    endfunction

endpackage

// File: rtl/fpc_to_ieee64.sv
// FloPoCo FP64 to IEEE-754 double, one register stage. The data register loads every cycle
// so a zero input clears it; push_out follows push_in by one cycle.
module fpc_to_ieee64 import mac_pkg::*; (
    input  logic             clk,
    input  logic             push_in,
    input  logic [FPC_W-1:0] fpc_in,
    output logic             push_out,
    output logic [63:0]      ieee_out
);

    fpc_t        f;
    logic [63:0] conv;

    assign f = fpc_t'(fpc_in);

    always_comb begin
        conv = 64'h7FF8_0000_0000_0000;
        unique case (f.exn)
            ExnZero:   conv = {f.sign, 63'd0};
            ExnNormal: begin
                if (f.exp == '1) begin
                    conv = {f.sign, 11'h7FF, 52'd0};
                end else if (f.exp == '0) begin
                    conv = {f.sign, 63'd0};
                end else begin
                    conv = {f.sign, f.exp, f.frac};
                end
            end
            ExnInf:    conv = {f.sign, 11'h7FF, 52'd0};
            default:   conv = 64'h7FF8_0000_0000_0000;
        endcase
    end

    always_ff @(posedge clk) begin
        push_out <= push_in;
        ieee_out <= conv;
    end

endmodule

// File: rtl/spmv_row_mac.sv
// Streaming FP64 row multiply-accumulate: products of consecutive equal-row nonzeros are summed
// and one IEEE double is emitted per row. Define MAC_ZERO_FILL_EN to emit zeros for skipped rows.
module spmv_row_mac import mac_pkg::*; #(
    parameter int unsigned INTERMEDIATOR_DEPTH      = 1024,
    parameter int unsigned LOG2_INTERMEDIATOR_DEPTH = 10,
    parameter int unsigned MUL_LAT                  = MUL_LAT_DEF,
    parameter int unsigned ADD_LAT                  = ADD_LAT_DEF,
    parameter int unsigned FIFO_DEPTH               = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                wr,
    input  logic [LOG2_INTERMEDIATOR_DEPTH-1:0] row,
    input  logic [63:0]                         v0,
    input  logic [63:0]                         v1,
    output logic                                push_out,
    output logic [63:0]                         v_out,
    input  logic                                eof,
    output logic                                stall,
    input  logic                                stall_out
);

    typedef logic [LOG2_INTERMEDIATOR_DEPTH-1:0] tag_t;

    // FIFO_DEPTH is a power of two so the pointers wrap on their own.
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    fpc_t             mul_res_q [MUL_LAT];
    tag_t             mul_tag_q [MUL_LAT];
    logic [MUL_LAT-1:0] mul_vld_q, mul_vld_d;
    fpc_t             add_res_q [ADD_LAT];
    logic [ADD_LAT-1:0] add_vld_q;
    fpc_t             fifo_val_q [FIFO_DEPTH];
    tag_t             fifo_tag_q [FIFO_DEPTH];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             stall_q, stall_d;

    acc_state_e       state_q, state_d;
    fpc_t             acc_q, acc_d;
    fpc_t             out_val_q, out_val_d;
    tag_t             cur_row_q, cur_row_d;
    tag_t             zcnt_q, zcnt_d;
    logic             has_row_q, has_row_d;
    logic             eof_q, eof_d;

    logic             accept, fifo_push, fifo_pop, fifo_empty, add_start, add_done, emit;
    logic             row_match;
    fpc_t             head_val;
    tag_t             head_tag;

    assign accept     = wr & ~stall_q;
    assign fifo_push  = mul_vld_q[MUL_LAT-1];
    assign fifo_empty = (cnt_q == '0);
    assign head_val   = fifo_val_q[rptr_q];
    assign head_tag   = fifo_tag_q[rptr_q];
    assign add_done   = add_vld_q[ADD_LAT-1];
    assign row_match  = (32'(head_tag) % INTERMEDIATOR_DEPTH) == (32'(cur_row_q) % INTERMEDIATOR_DEPTH);
    assign stall      = stall_q;

    always_comb begin
        mul_vld_d = {mul_vld_q[MUL_LAT-2:0], accept};
        cnt_d     = cnt_q + CntW'(fifo_push) - CntW'(fifo_pop);
        // Everything already committed must still fit in the FIFO.
        stall_d   = (int'(cnt_d) + $countones(mul_vld_d)) >= (int'(FIFO_DEPTH) - 1);
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        out_val_d = out_val_q;
        cur_row_d = cur_row_q;
        zcnt_d    = zcnt_q;
        has_row_d = has_row_q;
        eof_d     = eof_q | eof;
        fifo_pop  = 1'b0;
        add_start = 1'b0;
        emit      = 1'b0;
        unique case (state_q)
            StIdle, StAcc: begin
                if (!fifo_empty) begin
                    if (!has_row_q) begin
                        fifo_pop  = 1'b1;
                        acc_d     = head_val;
                        cur_row_d = head_tag;
                        has_row_d = 1'b1;
                        state_d   = StAcc;
                    end else if (row_match) begin
                        fifo_pop  = 1'b1;
                        add_start = 1'b1;
                        state_d   = StAddWait;
                    end else begin
                        out_val_d = acc_q;
                        state_d   = StEmit;
`ifdef MAC_ZERO_FILL_EN
                        zcnt_d    = head_tag - cur_row_q - tag_t'(1);
`endif
                    end
                end else if (eof_q && mul_vld_q == '0 && !accept) begin
                    out_val_d = acc_q;
                    state_d   = StFlush;
                end
            end
            StAddWait: begin
                if (add_done) begin
                    acc_d   = add_res_q[ADD_LAT-1];
                    state_d = StAcc;
                end
            end
            StEmit: begin
                if (!stall_out) begin
                    emit = 1'b1;
                    if (zcnt_q != '0) begin
                        zcnt_d    = zcnt_q - tag_t'(1);
                        out_val_d = '0;
                    end else begin
                        // The head product is loaded as the new row's first term next cycle.
                        has_row_d = 1'b0;
                        state_d   = StAcc;
                    end
                end
            end
            StFlush: begin
                if (!has_row_q) begin
                    eof_d   = eof;
                    state_d = StIdle;
                end else if (!stall_out) begin
                    emit      = 1'b1;
                    has_row_d = 1'b0;
                    eof_d     = eof;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mul_vld_q <= '0;
            add_vld_q <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            stall_q   <= 1'b1;
            state_q   <= StIdle;
            acc_q     <= '0;
            out_val_q <= '0;
            cur_row_q <= '0;
            zcnt_q    <= '0;
            has_row_q <= 1'b0;
            eof_q     <= 1'b0;
        end else begin
            mul_vld_q <= mul_vld_d;
            add_vld_q <= {add_vld_q[ADD_LAT-2:0], add_start};
            if (fifo_push) wptr_q <= wptr_q + PtrW'(1);
            if (fifo_pop) rptr_q <= rptr_q + PtrW'(1);
            cnt_q     <= cnt_d;
            stall_q   <= stall_d;
            state_q   <= state_d;
            acc_q     <= acc_d;
            out_val_q <= out_val_d;
            cur_row_q <= cur_row_d;
            zcnt_q    <= zcnt_d;
            has_row_q <= has_row_d;
            eof_q     <= eof_d;
        end
    end

    // Datapath registers; validity is tracked by the reset-cleared flags above.
    always_ff @(posedge clk) begin
        mul_res_q[0] <= fpc_mul(ieee_to_fpc(v0), ieee_to_fpc(v1));
        mul_tag_q[0] <= row;
        for (int i = 1; i < int'(MUL_LAT); i++) begin
            mul_res_q[i] <= mul_res_q[i-1];
            mul_tag_q[i] <= mul_tag_q[i-1];
        end
        add_res_q[0] <= fpc_add(acc_q, head_val);
        for (int i = 1; i < int'(ADD_LAT); i++) begin
            add_res_q[i] <= add_res_q[i-1];
        end
        if (fifo_push) begin
            fifo_val_q[wptr_q] <= mul_res_q[MUL_LAT-1];
            fifo_tag_q[wptr_q] <= mul_tag_q[MUL_LAT-1];
        end
    end

    fpc_to_ieee64 u_out_conv (
        .clk      (clk),
        .push_in  (emit & rst),
        .fpc_in   (rst ? out_val_q : fpc_t'('0)),
        .push_out (push_out),
        .ieee_out (v_out)
    );

endmodule

// File: tb/tb_spmv_row_mac.sv
// Directed self-checking bench for spmv_row_mac; expectations follow MAC_ZERO_FILL_EN when defined.
module tb_spmv_row_mac;

    localparam logic [63:0] D0_0  = 64'h0000_0000_0000_0000;
    localparam logic [63:0] D1_0  = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] D1_5  = 64'h3FF8_0000_0000_0000;
    localparam logic [63:0] D2_0  = 64'h4000_0000_0000_0000;
    localparam logic [63:0] D3_0  = 64'h4008_0000_0000_0000;
    localparam logic [63:0] D4_0  = 64'h4010_0000_0000_0000;
    localparam logic [63:0] D5_0  = 64'h4014_0000_0000_0000;
    localparam logic [63:0] D9_0  = 64'h4022_0000_0000_0000;
    localparam logic [63:0] D64_0 = 64'h4050_0000_0000_0000;
    localparam logic [63:0] DINF  = 64'h7FF0_0000_0000_0000;
    localparam logic [63:0] DNAN  = 64'h7FF8_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr;
    logic [9:0]  row;
    logic [63:0] v0;
    logic [63:0] v1;
    logic        push_out;
    logic [63:0] v_out;
    logic        eof;
    logic        stall;
    logic        stall_out;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [63:0] outs [$];
    int          pushes_stalled = 0;
    logic        saw_stall = 1'b0;

    spmv_row_mac dut (
        .clk       (clk),
        .rst       (rst),
        .wr        (wr),
        .row       (row),
        .v0        (v0),
        .v1        (v1),
        .push_out  (push_out),
        .v_out     (v_out),
        .eof       (eof),
        .stall     (stall),
        .stall_out (stall_out)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #1;
        if (push_out === 1'b1) begin
            outs.push_back(v_out);
            if (stall_out) pushes_stalled++;
        end
        if (wr && stall) saw_stall = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got %0d of required completion", 0);
        $fatal(1, "watchdog");
    end

    // Holds the nonzero until a clock edge with stall low takes it.
    task automatic send(input logic [9:0] r, input logic [63:0] a, input logic [63:0] b);
        int guard = 0;
        wr  = 1'b1;
        row = r;
        v0  = a;
        v1  = b;
        while (stall && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) begin
            n_checks++;
            n_fails++;
            $display("FAIL send_timeout: stall stayed %b, required 0", stall);
        end
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic pulse_eof();
        eof = 1'b1;
        @(negedge clk);
        eof = 1'b0;
    endtask

    task automatic wait_outputs(input int n);
        int guard = 0;
        while (outs.size() < n && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        repeat (40) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (push_out !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_push_out: got %b, required 0", push_out);
        end
        n_checks++;
        if (v_out !== 64'd0) begin
            n_fails++;
            $display("FAIL reset_v_out: got %h, required 0", v_out);
        end
        n_checks++;
        if (stall !== 1'b1) begin
            n_fails++;
            $display("FAIL reset_stall: got %b, required 1", stall);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b0) begin
            n_fails++;
            $display("FAIL release_stall: got %b, required 0", stall);
        end
    endtask

    task automatic test_single_row();
        outs.delete();
        send(10'd0, D2_0, D3_0);
        send(10'd0, D1_5, D2_0);
        pulse_eof();
        wait_outputs(1);
        n_checks++;
        if (outs.size() != 1) begin
            n_fails++;
            $display("FAIL single_row_count: got %0d, required 1", outs.size());
        end
        n_checks++;
        if (outs.size() < 1 || outs[0] !== D9_0) begin
            n_fails++;
            $display("FAIL single_row_value: got %h, required %h", (outs.size() > 0) ? outs[0] : 64'hx, D9_0);
        end
    endtask

    task automatic test_row_gap();
        logic [63:0] expv [$];
        outs.delete();
        expv.push_back(D1_0);
`ifdef MAC_ZERO_FILL_EN
        expv.push_back(D0_0);
`endif
        expv.push_back(D4_0);
        send(10'd0, D1_0, D1_0);
        send(10'd2, D2_0, D2_0);
        pulse_eof();
        wait_outputs(expv.size());
        n_checks++;
        if (outs.size() != expv.size()) begin
            n_fails++;
            $display("FAIL row_gap_count: got %0d, required %0d", outs.size(), expv.size());
        end
        for (int i = 0; i < expv.size(); i++) begin
            n_checks++;
            if (i >= outs.size() || outs[i] !== expv[i]) begin
                n_fails++;
                $display("FAIL row_gap_value[%0d]: got %h, required %h", i,
                         (i < outs.size()) ? outs[i] : 64'hx, expv[i]);
            end
        end
    endtask

    task automatic test_burst_stall();
        outs.delete();
        saw_stall = 1'b0;
        for (int i = 0; i < 64; i++) send(10'd7, D1_0, D1_0);
        pulse_eof();
        wait_outputs(1);
        n_checks++;
        if (saw_stall !== 1'b1) begin
            n_fails++;
            $display("FAIL burst_stall_seen: got %b, required 1", saw_stall);
        end
        n_checks++;
        if (outs.size() != 1) begin
            n_fails++;
            $display("FAIL burst_count: got %0d, required 1", outs.size());
        end
        n_checks++;
        if (outs.size() < 1 || outs[0] !== D64_0) begin
            n_fails++;
            $display("FAIL burst_value: got %h, required %h", (outs.size() > 0) ? outs[0] : 64'hx, D64_0);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] expv [3];
        expv[0] = D2_0;
        expv[1] = D3_0;
        expv[2] = D5_0;
        outs.delete();
        pushes_stalled = 0;
        stall_out = 1'b1;
        send(10'd10, D1_0, D2_0);
        send(10'd11, D3_0, D1_0);
        send(10'd12, D2_0, D2_0);
        send(10'd12, D1_0, D1_0);
        pulse_eof();
        repeat (50) @(negedge clk);
        n_checks++;
        if (outs.size() != 0) begin
            n_fails++;
            $display("FAIL backpressure_held: got %0d pushes, required 0", outs.size());
        end
        stall_out = 1'b0;
        wait_outputs(3);
        n_checks++;
        if (pushes_stalled != 0) begin
            n_fails++;
            $display("FAIL push_during_stall: got %0d, required 0", pushes_stalled);
        end
        n_checks++;
        if (outs.size() != 3) begin
            n_fails++;
            $display("FAIL backpressure_count: got %0d, required 3", outs.size());
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= outs.size() || outs[i] !== expv[i]) begin
                n_fails++;
                $display("FAIL backpressure_value[%0d]: got %h, required %h", i,
                         (i < outs.size()) ? outs[i] : 64'hx, expv[i]);
            end
        end
    endtask

    task automatic test_wrap_nan();
        logic [63:0] expv [3];
        expv[0] = D1_0;
        expv[1] = D1_0;
        expv[2] = DNAN;
        outs.delete();
        send(10'd1023, D1_0, D1_0);
        send(10'd0, D1_0, D1_0);
        send(10'd1, DINF, D0_0);
        pulse_eof();
        wait_outputs(3);
        n_checks++;
        if (outs.size() != 3) begin
            n_fails++;
            $display("FAIL wrap_count: got %0d, required 3", outs.size());
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= outs.size() || outs[i] !== expv[i]) begin
                n_fails++;
                $display("FAIL wrap_value[%0d]: got %h, required %h", i,
                         (i < outs.size()) ? outs[i] : 64'hx, expv[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        outs.delete();
        send(10'd3, D2_0, D2_0);
        send(10'd3, D1_0, D1_0);
        send(10'd4, D1_0, D1_0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (push_out !== 1'b0) begin
            n_fails++;
            $display("FAIL mid_reset_push_out: got %b, required 0", push_out);
        end
        n_checks++;
        if (v_out !== 64'd0) begin
            n_fails++;
            $display("FAIL mid_reset_v_out: got %h, required 0", v_out);
        end
        n_checks++;
        if (stall !== 1'b1) begin
            n_fails++;
            $display("FAIL mid_reset_stall: got %b, required 1", stall);
        end
        rst = 1'b1;
        @(negedge clk);
        outs.delete();
        send(10'd5, D3_0, D1_0);
        pulse_eof();
        wait_outputs(1);
        n_checks++;
        if (outs.size() != 1) begin
            n_fails++;
            $display("FAIL mid_reset_count: got %0d, required 1", outs.size());
        end
        n_checks++;
        if (outs.size() < 1 || outs[0] !== D3_0) begin
            n_fails++;
            $display("FAIL mid_reset_value: got %h, required %h", (outs.size() > 0) ? outs[0] : 64'hx, D3_0);
        end
    endtask

    initial begin
        rst       = 1'b0;
        wr        = 1'b0;
        row       = '0;
        v0        = '0;
        v1        = '0;
        eof       = 1'b0;
        stall_out = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_row();
        test_row_gap();
        test_burst_stall();
        test_backpressure();
        test_wrap_nan();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
